wb_write_buffer: RTL
====================

Name: wb_write_buffer

Overview:
Write-back buffer between the cache controller's memory port and the unified main memory. Dirty-line evictions are absorbed into a small FIFO so that line fills are not stalled behind them. Buffered lines drain to memory in the background. Reads that hit a buffered line are forwarded from the buffer; reads that miss go straight to memory ahead of pending drains.

Parameters:
DEPTH, 4, number of 64-bit line entries (power of two, 2..8)
CNT_W, 3, width of occupancy count, must satisfy 2**CNT_W > DEPTH

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
addr  in  14  upstream line address (word address [15:2])
re  in  1  upstream line read request, held until rdy
we  in  1  upstream line write (eviction) request, held until rdy
wdata  in  64  upstream eviction data, stable while we held
rd_data  out  64  line read data, valid when rdy=1 for a read
rdy  out  1  one-cycle completion pulse for the current upstream request
m_addr  out  14  memory line address
m_re  out  1  memory read, held until m_rdy
m_we  out  1  memory write, held until m_rdy
m_wdata  out  64  memory write data
m_rd_data  in  64  memory read data, valid when m_rdy=1
m_rdy  in  1  memory one-cycle completion pulse
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  CNT_W  valid entries

Behaviour:
- Reset (async, rst_n=0): FIFO empty, head/tail=0, all valid bits 0, state IDLE. Outputs: rdy=0, rd_data=0, m_re=0, m_we=0, m_addr=0, m_wdata=0, count=0, empty=1, full=0.
- Upstream protocol: re and we are mutually exclusive. The request is held until rdy. rdy is registered and high for exactly one cycle. re/we are ignored in the cycle rdy=1.
- Memory FSM states: IDLE, MRD, MWR. m_re=1 only in MRD; m_we=1 only in MWR. m_addr and m_wdata are registered and stable for the whole transaction. A memory transaction is never aborted.
- Write accept (any state, request pending, rdy=0):
  - If addr matches a valid entry that is not the head being drained in MWR, overwrite that entry's data in place. count unchanged.
  - Else, if not full, enqueue at tail and increment count.
  - Either way, rdy=1 the next cycle.
  - If full and no coalesce is possible, hold with no rdy. Accept in the cycle after the dequeue.
- Read, buffer hit (any state): addr matches a valid entry. rd_data is the youngest matching entry's data, with rdy the next cycle. Latency is 1.
- Read, buffer miss:
  - In IDLE: go to MRD next cycle with m_addr=addr.
  - In MWR: wait for the drain to finish, then MRD. Reads have priority over the next drain.
  - In MRD, when m_rdy=1: rd_data<=m_rd_data and rdy=1 the next cycle, then IDLE.
  - Miss latency is memory latency + 2 cycles from IDLE.
- Drain: in IDLE with no read miss pending and empty=0, go to MWR with m_addr/m_wdata = head entry.
  - In MWR, when m_rdy=1: invalidate the head, advance head (mod DEPTH), decrement count, then IDLE.
- Simultaneous enqueue and dequeue in one cycle: count unchanged; head and tail both advance.
- Pointer wrap: head and tail wrap DEPTH-1 to 0.
- Ordering: duplicate addresses arise only via the head-drain rule, so they drain oldest first. Memory therefore ends with the youngest data.
- full and empty are combinational from count.
- Reset asserted mid-transaction clears everything immediately. Buffered lines are lost; this is acceptable only at system reset.

Test Plan:
- Reset with rst_n=0 while we=1 -> rdy=0, m_re=m_we=0, count=0, empty=1. After release with no requests, no memory activity.
- Write addr=14'h0010, wdata=64'hA5A5_0000_0000_0001 -> rdy one cycle later. count=1. Drain issues m_we with m_addr=0010 and that data. After m_rdy, count=0 and empty=1.
- Hold m_rdy low, write 4 distinct lines (0x1,0x2,0x3,0x4) then a 5th (0x5) -> full=1 and 5th has no rdy. Pulse m_rdy -> head 0x1 retired, 0x5 accepted next cycle, count=4, drain order 1,2,3,4,5.
- Write 0x20=data1, then 0x20=data2 while 0x20 not draining -> count stays 1. Read 0x20 returns data2 with 1-cycle rdy and no m_re.
- Write 0x20 while entry 0x20 is mid-drain (MWR) -> new entry, count=2, m_wdata unchanged. Read 0x20 returns the new data. Memory receives the old then the new value.
- Read miss 0x3FFF while MWR pending, memory latency 4 -> m_re issued only after the drain's m_rdy. Read precedes the next drain. rd_data=m_rd_data and rdy exactly one cycle.

Source files
------------

// File: rtl/wb_write_buffer.sv
// wb_write_buffer: posted write-back buffer between the cache memory port and main memory.
// Latency: writes and read hits complete 1 cycle after the request; a read miss from IDLE takes memory latency + 2.
// Backpressure: a write with no coalesce target is held while full; read misses wait behind an in-flight drain.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   addr/re/we/wdata      upstream line request (held until rdy), eviction data
//   rd_data/rdy           upstream read data and one-cycle completion pulse
//   m_addr/m_re/m_we      memory request (held until m_rdy), m_wdata write data
//   m_rd_data/m_rdy       memory read data and one-cycle completion pulse
//   full/empty/count      buffer occupancy
module wb_write_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [13:0]      addr,
    input  logic             re,
    input  logic             we,
    input  logic [63:0]      wdata,
    output logic [63:0]      rd_data,
    output logic             rdy,
    output logic [13:0]      m_addr,
    output logic             m_re,
    output logic             m_we,
    output logic [63:0]      m_wdata,
    input  logic [63:0]      m_rd_data,
    input  logic             m_rdy,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MRD  = 2'd1,
        ST_MWR  = 2'd2
    } state_t;

    state_t           r_state;
    logic [DEPTH-1:0] r_vld;
    logic [13:0]      r_addr [DEPTH];
    logic [63:0]      r_dat  [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_rdy;
    logic             r_m_re;
    logic             r_m_we;
    logic [13:0]      r_m_addr;
    logic [63:0]      r_m_wdata;
    logic [63:0]      r_rd_data;

    logic             w_full;
    logic             w_empty;
    logic             w_req;
    logic             w_wr;
    logic             w_rd;
    logic             w_rd_hit;
    logic             w_wr_hit;
    logic [PTR_W-1:0] w_rd_idx;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_scan_idx;
    logic             w_coalesce;
    logic             w_enq;
    logic             w_rd_hit_go;
    logic             w_rd_miss;
    logic             w_drain_start;
    logic             w_drain_done;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A request is ignored during its own rdy cycle so it is not serviced twice.
    assign w_req = (re | we) & ~r_rdy;
    assign w_wr  = w_req & we;
    assign w_rd  = w_req & re & ~we;

    // Scan oldest to youngest so the last match is the youngest copy of a line.
    // The head being written out is excluded from write coalescing: its data is
    // already committed to the memory bus, so a new write must create a new entry.
    always_comb begin
        w_rd_hit   = 1'b0;
        w_wr_hit   = 1'b0;
        w_rd_idx   = '0;
        w_wr_idx   = '0;
        w_scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan_idx = r_head + PTR_W'(k);
            if (r_vld[w_scan_idx] && (r_addr[w_scan_idx] == addr)) begin
                w_rd_hit = 1'b1;
                w_rd_idx = w_scan_idx;
                if (!((r_state == ST_MWR) && (w_scan_idx == r_head))) begin
                    w_wr_hit = 1'b1;
                    w_wr_idx = w_scan_idx;
                end
            end
        end
    end

    assign w_coalesce    = w_wr & w_wr_hit;
    assign w_enq         = w_wr & ~w_wr_hit & ~w_full;
    assign w_rd_hit_go   = w_rd & w_rd_hit;
    assign w_rd_miss     = w_rd & ~w_rd_hit;
    assign w_drain_done  = (r_state == ST_MWR) & m_rdy;
    // Read misses take priority over starting the next drain.
    assign w_drain_start = (r_state == ST_IDLE) & ~w_rd_miss & ~w_empty;

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_dat[i]  <= '0;
            end
        end else begin
            if (w_enq) begin
                r_addr[r_tail] <= addr;
                r_dat[r_tail]  <= wdata;
            end
            if (w_coalesce) begin
                r_dat[w_wr_idx] <= wdata;
            end
        end
    end

    // Valid bits, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            // A drain retires a non-empty head, so tail != head whenever both fire.
            if (w_drain_done) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + PTR_W'(1);
            end
            case ({w_enq, w_drain_done})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Memory FSM and registered upstream/memory outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rdy     <= 1'b0;
            r_rd_data <= '0;
            r_m_re    <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
        end else begin
            r_rdy <= 1'b0;
            if (w_coalesce || w_enq) begin
                r_rdy <= 1'b1;
            end
            if (w_rd_hit_go) begin
                r_rd_data <= r_dat[w_rd_idx];
                r_rdy     <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_miss) begin
                        r_state  <= ST_MRD;
                        r_m_re   <= 1'b1;
                        r_m_addr <= addr;
                    end else if (w_drain_start) begin
                        r_state  <= ST_MWR;
                        r_m_we   <= 1'b1;
                        r_m_addr <= r_addr[r_head];
                        // A write coalescing into the head in this same cycle must
                        // be what goes out, or its data would be lost on retire.
                        if (w_coalesce && (w_wr_idx == r_head)) begin
                            r_m_wdata <= wdata;
                        end else begin
                            r_m_wdata <= r_dat[r_head];
                        end
                    end
                end
                ST_MRD: begin
                    if (m_rdy) begin
                        r_state   <= ST_IDLE;
                        r_m_re    <= 1'b0;
                        r_rd_data <= m_rd_data;
                        r_rdy     <= 1'b1;
                    end
                end
                ST_MWR: begin
                    if (m_rdy) begin
                        r_state <= ST_IDLE;
                        r_m_we  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_m_re  <= 1'b0;
                    r_m_we  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data = r_rd_data;
    assign rdy     = r_rdy;
    assign m_addr  = r_m_addr;
    assign m_re    = r_m_re;
    assign m_we    = r_m_we;
    assign m_wdata = r_m_wdata;
    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = r_count;

endmodule
